// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialisation sequencer: delay, PRECHARGE-ALL, AUTO REFRESH burst, MRS.
// Define SDRAM_EXT_MODE_EN to add an EMRS step (ba = 2'b10) after the MRS gap.
module sdram_init_ctrl #(
  parameter int ADDR_WIDTH   = 12,
  parameter int PWRUP_CYCLES = 20000,
  parameter int TRP_CYCLES   = 2,
  parameter int TRFC_CYCLES  = 7,
  parameter int TMRD_CYCLES  = 2,
  parameter int REF_COUNT    = 8,
  parameter logic [ADDR_WIDTH-1:0] MODE_REG = ADDR_WIDTH'(12'b0000_0011_0111)
`ifdef SDRAM_EXT_MODE_EN
  ,
  parameter logic [ADDR_WIDTH-1:0] EXT_MODE_REG = '0
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reinit_req,
  output logic [3:0]            sdram_cmd,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [1:0]            sdram_ba,
  output logic                  init_end,
  output logic                  init_busy
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int MAX_GAP = (TRP_CYCLES >= TRFC_CYCLES && TRP_CYCLES >= TMRD_CYCLES) ? TRP_CYCLES :
                           ((TRFC_CYCLES >= TMRD_CYCLES) ? TRFC_CYCLES : TMRD_CYCLES);
  localparam int TMR_W = (MAX_GAP > 2) ? $clog2(MAX_GAP) : 1;
  localparam int PWR_W = $clog2(PWRUP_CYCLES + 1);
  localparam int REF_W = $clog2(REF_COUNT + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IDLE = ADDR_WIDTH'(1) << 10;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_PRE,
    S_TRP,
    S_REF,
    S_TRFC,
    S_MRS,
    S_TMRD,
`ifdef SDRAM_EXT_MODE_EN
    S_EMRS,
    S_TMRD2,
`endif
    S_DONE
  } state_t;

`ifdef SDRAM_EXT_MODE_EN
  localparam state_t AFTER_MRS = S_EMRS;
`else
  localparam state_t AFTER_MRS = S_DONE;
`endif

  state_t                  state_q, state_d;
  logic [PWR_W-1:0]        pwr_cnt_q, pwr_cnt_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [REF_W-1:0]        ref_cnt_q, ref_cnt_d;
  logic [3:0]              cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              ba_q, ba_d;
  logic                    init_end_q, init_end_d;
  logic                    init_busy_q, init_busy_d;

  // A gap of N cycles is one command cycle plus N-1 wait cycles (timer 0..N-2).
  function automatic logic gap_done(input logic [TMR_W-1:0] t, input int gap);
    return t == TMR_W'(gap - 2);
  endfunction

  always_comb begin
    state_d   = state_q;
    pwr_cnt_d = pwr_cnt_q;
    tmr_d     = tmr_q;
    ref_cnt_d = ref_cnt_q;

    case (state_q)
      S_PWRUP: begin
        if (pwr_cnt_q == PWR_W'(PWRUP_CYCLES)) state_d = S_PRE;
        else                                    pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
      end
      S_PRE: begin
        tmr_d   = '0;
        state_d = (TRP_CYCLES > 1) ? S_TRP : S_REF;
      end
      S_TRP: begin
        if (gap_done(tmr_q, TRP_CYCLES)) state_d = S_REF;
        else                             tmr_d   = tmr_q + TMR_W'(1);
      end
      S_REF: begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        tmr_d     = '0;
        if (TRFC_CYCLES > 1) state_d = S_TRFC;
        else                 state_d = (ref_cnt_d < REF_W'(REF_COUNT)) ? S_REF : S_MRS;
      end
      S_TRFC: begin
        if (gap_done(tmr_q, TRFC_CYCLES))
          state_d = (ref_cnt_q < REF_W'(REF_COUNT)) ? S_REF : S_MRS;
        else
          tmr_d = tmr_q + TMR_W'(1);
      end
      S_MRS: begin
        tmr_d   = '0;
        state_d = (TMRD_CYCLES > 1) ? S_TMRD : AFTER_MRS;
      end
      S_TMRD: begin
        if (gap_done(tmr_q, TMRD_CYCLES)) state_d = AFTER_MRS;
        else                              tmr_d   = tmr_q + TMR_W'(1);
      end
`ifdef SDRAM_EXT_MODE_EN
      S_EMRS: begin
        tmr_d   = '0;
        state_d = (TMRD_CYCLES > 1) ? S_TMRD2 : S_DONE;
      end
      S_TMRD2: begin
        if (gap_done(tmr_q, TMRD_CYCLES)) state_d = S_DONE;
        else                              tmr_d   = tmr_q + TMR_W'(1);
      end
`endif
      S_DONE: begin
        // Re-init skips the power-up delay and restarts the refresh count.
        if (reinit_req) begin
          state_d   = S_PRE;
          ref_cnt_d = '0;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    // Outputs are registered from the next state so commands appear with the state.
    cmd_d       = CMD_NOP;
    addr_d      = ADDR_IDLE;
    ba_d        = 2'b00;
    init_end_d  = (state_d == S_DONE);
    init_busy_d = (state_d != S_DONE);
    case (state_d)
      S_PRE: cmd_d = CMD_PRE;
      S_REF: cmd_d = CMD_REF;
      S_MRS: begin
        cmd_d  = CMD_MRS;
        addr_d = MODE_REG;
      end
`ifdef SDRAM_EXT_MODE_EN
      S_EMRS: begin
        cmd_d  = CMD_MRS;
        addr_d = EXT_MODE_REG;
        ba_d   = 2'b10;
      end
`endif
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      pwr_cnt_q   <= '0;
      tmr_q       <= '0;
      ref_cnt_q   <= '0;
      cmd_q       <= CMD_NOP;
      addr_q      <= ADDR_IDLE;
      ba_q        <= 2'b00;
      init_end_q  <= 1'b0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      tmr_q       <= tmr_d;
      ref_cnt_q   <= ref_cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      ba_q        <= ba_d;
      init_end_q  <= init_end_d;
      init_busy_q <= init_busy_d;
    end
  end

  assign sdram_cmd  = cmd_q;
  assign sdram_addr = addr_q;
  assign sdram_ba   = ba_q;
  assign init_end   = init_end_q;
  assign init_busy  = init_busy_q;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Scoreboard bench for sdram_init_ctrl: a default-timing instance and a back-to-back instance.
// Define SDRAM_EXT_MODE_EN for both RTL and bench to cover the EMRS step.
module tb_sdram_init_ctrl;

  localparam int P_A = 20000, TRP_A = 2, TRFC_A = 7, TMRD_A = 2, NREF_A = 8;
  localparam int P_B = 10,    TRP_B = 1, TRFC_B = 1, TMRD_B = 1, NREF_B = 1;
  localparam logic [11:0] MODE  = 12'h037;
  localparam logic [11:0] EXT_A = 12'h020;
  localparam logic [11:0] IDLE  = 12'h400;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;
  localparam int K_CMD = 0, K_RISE = 1, K_FALL = 2;

  typedef struct {
    int          idx;
    int          cyc;
    int          kind;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  ba;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b, reinit_a, reinit_b;
  logic [3:0]  cmd_a, cmd_b;
  logic [11:0] addr_a, addr_b;
  logic [1:0]  ba_a, ba_b;
  logic        end_a, end_b, busy_a, busy_b;

  int   cyc = -1;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic [1:0] exp_end = 2'b00;

  sdram_init_ctrl #(
    .ADDR_WIDTH(12), .PWRUP_CYCLES(P_A), .TRP_CYCLES(TRP_A), .TRFC_CYCLES(TRFC_A),
    .TMRD_CYCLES(TMRD_A), .REF_COUNT(NREF_A), .MODE_REG(MODE)
`ifdef SDRAM_EXT_MODE_EN
    , .EXT_MODE_REG(EXT_A)
`endif
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .reinit_req(reinit_a), .sdram_cmd(cmd_a),
    .sdram_addr(addr_a), .sdram_ba(ba_a), .init_end(end_a), .init_busy(busy_a)
  );

  sdram_init_ctrl #(
    .ADDR_WIDTH(12), .PWRUP_CYCLES(P_B), .TRP_CYCLES(TRP_B), .TRFC_CYCLES(TRFC_B),
    .TMRD_CYCLES(TMRD_B), .REF_COUNT(NREF_B), .MODE_REG(MODE)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .reinit_req(reinit_b), .sdram_cmd(cmd_b),
    .sdram_addr(addr_b), .sdram_ba(ba_b), .init_end(end_b), .init_busy(busy_b)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic push_ev(input int idx, input int c, input int kind,
                         input logic [3:0] cmd, input logic [11:0] addr, input logic [1:0] ba);
    ev_t e;
    e.idx = idx; e.cyc = c; e.kind = kind; e.cmd = cmd; e.addr = addr; e.ba = ba;
    exp_q.push_back(e);
  endtask

  // Reference model: from the PRECHARGE cycle, lay out every command and the init_end rise.
  task automatic push_seq(input int idx, input int t_pre, output int done_cyc);
    int t, trp, trfc, tmrd, nref;
`ifdef SDRAM_EXT_MODE_EN
    logic [11:0] ext;
    ext = (idx == 0) ? EXT_A : 12'h000;
`endif
    trp  = (idx == 0) ? TRP_A  : TRP_B;
    trfc = (idx == 0) ? TRFC_A : TRFC_B;
    tmrd = (idx == 0) ? TMRD_A : TMRD_B;
    nref = (idx == 0) ? NREF_A : NREF_B;
    t = t_pre;
    push_ev(idx, t, K_CMD, PRE, IDLE, 2'b00);
    t += trp;
    for (int k = 0; k < nref; k++) begin
      push_ev(idx, t, K_CMD, REF, IDLE, 2'b00);
      t += trfc;
    end
    push_ev(idx, t, K_CMD, MRS, MODE, 2'b00);
    t += tmrd;
`ifdef SDRAM_EXT_MODE_EN
    push_ev(idx, t, K_CMD, MRS, ext, 2'b10);
    t += tmrd;
`endif
    push_ev(idx, t, K_RISE, NOP, IDLE, 2'b00);
    done_cyc = t;
  endtask

  function automatic int first_of(input int idx);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].idx == idx) return i;
    return -1;
  endfunction

  function automatic int count_of(input int idx);
    int n = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].idx == idx) n++;
    return n;
  endfunction

  task automatic flush_after(input int idx, input int c);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].idx == idx && exp_q[i].cyc > c) exp_q.delete(i);
  endtask

  task automatic expect_cmd(input int idx, input logic [3:0] cmd, input logic [11:0] addr,
                            input logic [1:0] ba);
    int i;
    i = first_of(idx);
    if (i < 0 || exp_q[i].cyc != cyc || exp_q[i].kind != K_CMD) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d unexpected command at cycle %0d: got %b, expected NOP", idx, cyc, cmd);
    end else begin
      checkOutput($sformatf("dut%0d cmd", idx), 32'(cmd), 32'(exp_q[i].cmd));
      checkOutput($sformatf("dut%0d addr", idx), 32'(addr), 32'(exp_q[i].addr));
      checkOutput($sformatf("dut%0d ba", idx), 32'(ba), 32'(exp_q[i].ba));
      exp_q.delete(i);
    end
  endtask

  task automatic monitor_step(input int idx, input logic [3:0] cmd, input logic [11:0] addr,
                              input logic [1:0] ba, input logic ie, input logic ib);
    int i;
    i = first_of(idx);
    while (i >= 0 && exp_q[i].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d missed event: got none by cycle %0d, expected kind %0d cmd %b at cycle %0d",
               idx, cyc, exp_q[i].kind, exp_q[i].cmd, exp_q[i].cyc);
      exp_q.delete(i);
      i = first_of(idx);
    end
    if (i >= 0 && exp_q[i].cyc == cyc && exp_q[i].kind != K_CMD) begin
      exp_end[idx] = (exp_q[i].kind == K_RISE);
      exp_q.delete(i);
    end
    checkOutput($sformatf("dut%0d init_end", idx), 32'(ie), 32'(exp_end[idx]));
    checkOutput($sformatf("dut%0d init_busy", idx), 32'(ib), 32'(!exp_end[idx]));
    if (cmd !== NOP) expect_cmd(idx, cmd, addr, ba);
    else begin
      checkOutput($sformatf("dut%0d idle addr", idx), 32'(addr), 32'(IDLE));
      checkOutput($sformatf("dut%0d idle ba", idx), 32'(ba), 32'(2'b00));
    end
  endtask

  always @(negedge clk) begin
    monitor_step(0, cmd_a, addr_a, ba_a, end_a, busy_a);
    monitor_step(1, cmd_b, addr_b, ba_b, end_b, busy_b);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cycle();
  endtask

  // One-cycle reinit pulse, high during the current cycle.
  task automatic applyStimulus(input int idx);
    if (idx == 0) reinit_a = 1'b1; else reinit_b = 1'b1;
    next_cycle();
    if (idx == 0) reinit_a = 1'b0; else reinit_b = 1'b0;
  endtask

  task automatic drain(input int idx, input int budget, input string name);
    int n = 0;
    while (count_of(idx) > 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({name, " pending events"}, 32'(count_of(idx)), 32'd0);
    flush_after(idx, -2);
    next_cycle();
  endtask

  task automatic check_reset(input int idx);
    checkOutput($sformatf("dut%0d reset cmd", idx), 32'(idx == 0 ? cmd_a : cmd_b), 32'(NOP));
    checkOutput($sformatf("dut%0d reset addr", idx), 32'(idx == 0 ? addr_a : addr_b), 32'(IDLE));
    checkOutput($sformatf("dut%0d reset ba", idx), 32'(idx == 0 ? ba_a : ba_b), 32'd0);
    checkOutput($sformatf("dut%0d reset end", idx), 32'(idx == 0 ? end_a : end_b), 32'd0);
    checkOutput($sformatf("dut%0d reset busy", idx), 32'(idx == 0 ? busy_a : busy_b), 32'd1);
  endtask

  initial begin
    int base, done_c, t, k;
    rst_n_a = 1'b0; rst_n_b = 1'b0; reinit_a = 1'b0; reinit_b = 1'b0;
    next_cycle();
    next_cycle();
    check_reset(0);
    check_reset(1);

    $display("[TB] back-to-back instance: init then reinit");
    base = cyc + 1;
    push_seq(1, base + P_B, done_c);
    rst_n_b = 1'b1;
    drain(1, done_c - cyc + 5, "b init");
    repeat (int'($urandom_range(1, 5))) next_cycle();
    t = cyc;
    push_ev(1, t + 1, K_FALL, NOP, IDLE, 2'b00);
    push_seq(1, t + 1, done_c);
    applyStimulus(1);
    drain(1, done_c - cyc + 5, "b reinit");

    $display("[TB] default instance: init with ignored reinit pulses");
    base = cyc + 1;
    push_seq(0, base + P_A, done_c);
    rst_n_a = 1'b1;
    wait_until(base + int'($urandom_range(0, P_A - 10)));
    applyStimulus(0);
    k = int'($urandom_range(0, NREF_A - 1));
    wait_until(base + P_A + TRP_A + TRFC_A * k + 1 + int'($urandom_range(0, TRFC_A - 2)));
    applyStimulus(0);
    wait_until(done_c - 1);
    applyStimulus(0);
    drain(0, done_c - cyc + 5, "a init");
    repeat (int'($urandom_range(5, 20))) next_cycle();

    $display("[TB] default instance: reinit");
    t = cyc;
    push_ev(0, t + 1, K_FALL, NOP, IDLE, 2'b00);
    push_seq(0, t + 1, done_c);
    applyStimulus(0);
    drain(0, done_c - cyc + 5, "a reinit");

    $display("[TB] default instance: reset during refresh burst");
    t = cyc;
    push_ev(0, t + 1, K_FALL, NOP, IDLE, 2'b00);
    push_seq(0, t + 1, done_c);
    applyStimulus(0);
    k = t + 1 + TRP_A + TRFC_A * int'($urandom_range(1, NREF_A - 2)) + int'($urandom_range(0, TRFC_A - 1));
    wait_until(k);
    rst_n_a = 1'b0;
    flush_after(0, k);
    next_cycle();
    exp_end[0] = 1'b0;
    check_reset(0);
    rst_n_a = 1'b1;
    base = cyc + 1;
    push_seq(0, base + P_A, done_c);
    drain(0, done_c - cyc + 5, "a after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
